lsu_mem_responder: RTL and testbench

- Data-memory responder serving the load/store issue unit's memory request interface.
- Accepts one read or write per request and holds a byte-addressable, word-organised RAM.
- Returns `mem_done` after a configurable latency, plus sign/zero-extended load data in the 33-bit tagged format (bit 32 = valid) used across the datapath.
- Sits between the LSU issue stage and writeback.

---
 rtl/lsu_mem_responder.sv | 172 +++++++++++++++++
 tb/tb_lsu_mem_responder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_responder.sv
// Load/store data-memory responder: word RAM with byte/half/word access, extended 33-bit tagged load data.
// Latency: mem_done pulses LATENCY edges after accept; one idle cycle minimum between requests.
// Backpressure: req is a level held until mem_done; optional MEM_MISALIGN_TRAP_EN adds misalign_err.
module lsu_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        read_mem,
  input  logic        write_mem,
  input  logic [5:0]  ex_type,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic        mem_done,
  output logic [32:0] read_data,
  output logic        busy
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        misalign_err
`endif
);

  localparam logic [5:0] OP_LB  = 6'd21;
  localparam logic [5:0] OP_LH  = 6'd22;
  localparam logic [5:0] OP_LW  = 6'd23;
  localparam logic [5:0] OP_LBU = 6'd24;
  localparam logic [5:0] OP_LHU = 6'd25;
  localparam logic [5:0] OP_SB  = 6'd26;
  localparam logic [5:0] OP_SH  = 6'd27;
  localparam logic [5:0] OP_SW  = 6'd28;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt;
  logic                  accept, access;
  logic [ADDR_WIDTH+1:0] a_q;
  logic [31:0]           wd_q;
  logic [5:0]            op_q;
  logic                  rd_q;
  logic                  is_ld, is_st, misal;
  logic [31:0]           rword, ld_dat, st_dat;
  logic [7:0]            bsel;
  logic [15:0]           hsel;
  logic [3:0]            be;
  logic                  unused_addr;

  logic [31:0] mem [2**ADDR_WIDTH];

  // Address bits above the RAM span wrap and are intentionally dropped.
  assign unused_addr = ^addr[31:ADDR_WIDTH+2];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_done  = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    access    = 1'b0;
    case (state)
      IDLE: if (req && (read_mem ^ write_mem)) begin
        accept    = 1'b1;
        state_nxt = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (cnt == 4'd0) begin
          access    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        busy      = 1'b1;
        mem_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign is_ld = rd_q && (op_q inside {[OP_LB:OP_LHU]});
  assign is_st = !rd_q && (op_q inside {[OP_SB:OP_SW]});

`ifdef MEM_MISALIGN_TRAP_EN
  logic mis_q;
  assign misal = (((op_q == OP_LH) || (op_q == OP_LHU) || (op_q == OP_SH)) && a_q[0]) ||
                 (((op_q == OP_LW) || (op_q == OP_SW)) && (a_q[1:0] != 2'b00));
  assign misalign_err = mem_done && mis_q;
`else
  assign misal = 1'b0;
`endif

  assign rword = mem[a_q[ADDR_WIDTH+1:2]];
  assign bsel  = rword[{a_q[1:0], 3'b000} +: 8];
  assign hsel  = a_q[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    ld_dat = rword;
    case (op_q)
      OP_LB:   ld_dat = {{24{bsel[7]}}, bsel};
      OP_LH:   ld_dat = {{16{hsel[15]}}, hsel};
      OP_LBU:  ld_dat = {24'd0, bsel};
      OP_LHU:  ld_dat = {16'd0, hsel};
      default: ld_dat = rword;
    endcase
  end

  // Lane data is replicated so the byte enables alone pick the target bytes.
  always_comb begin
    be     = 4'b1111;
    st_dat = wd_q;
    case (op_q)
      OP_SB: begin
        be     = 4'b0001 << a_q[1:0];
        st_dat = {4{wd_q[7:0]}};
      end
      OP_SH: begin
        be     = a_q[1] ? 4'b1100 : 4'b0011;
        st_dat = {2{wd_q[15:0]}};
      end
      default: begin
        be     = 4'b1111;
        st_dat = wd_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && access && is_st && !misal) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[a_q[ADDR_WIDTH+1:2]][8*b +: 8] <= st_dat[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 4'd0;
      read_data <= 33'd0;
      a_q       <= '0;
      wd_q      <= 32'd0;
      op_q      <= 6'd0;
      rd_q      <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q     <= 1'b0;
`endif
    end else begin
      if (accept) begin
        a_q           <= addr[ADDR_WIDTH+1:0];
        wd_q          <= write_data;
        op_q          <= ex_type;
        rd_q          <= read_mem;
        cnt           <= 4'(LATENCY - 1);
        read_data[32] <= 1'b0;
      end else if ((state == BUSY) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (access && is_ld && !misal) read_data <= {1'b1, ld_dat};
`ifdef MEM_MISALIGN_TRAP_EN
      if (accept)      mis_q <= 1'b0;
      else if (access) mis_q <= misal && (is_ld || is_st);
`endif
    end
  end

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Bench for lsu_mem_responder: vector table through a scoreboard queue plus hand-built corner sequences.
module tb_lsu_mem_responder;
  localparam int LAT = 2;

  localparam logic [5:0] LB = 6'd21, LH = 6'd22, LW = 6'd23, LBU = 6'd24, LHU = 6'd25;
  localparam logic [5:0] SB = 6'd26, SH = 6'd27, SW = 6'd28;

  logic        clk = 1'b0;
  logic        rst, req, read_mem, write_mem;
  logic [5:0]  ex_type;
  logic [31:0] addr, write_data;
  logic        mem_done, busy;
  logic [32:0] read_data;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lsu_mem_responder #(.ADDR_WIDTH(10), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .read_mem(read_mem), .write_mem(write_mem),
    .ex_type(ex_type), .addr(addr), .write_data(write_data),
    .mem_done(mem_done), .read_data(read_data), .busy(busy)
`ifdef MEM_MISALIGN_TRAP_EN
    , .misalign_err(misalign_err)
`endif
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] wd;
    logic        full;
    logic [32:0] exp;
    logic        mis;
  } vec_t;

  typedef struct {
    logic        full;
    logic [32:0] exp;
    logic        mis;
  } sb_t;

  sb_t  sbq[$];
  vec_t vt[20];

  task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept", 33'(ok), 33'd1);
  endtask

  task automatic do_req(input logic rd, input logic wr, input logic [5:0] op,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic full, input logic [32:0] exp, input logic mis);
    int  n;
    bit  ok;
    sb_t e;
    @(negedge clk);
    req = 1'b1; read_mem = rd; write_mem = wr; ex_type = op; addr = a; write_data = wd;
    sbq.push_back('{full: full, exp: exp, mis: mis});
    wait_accept(ok);
    n = 0;
    while (ok && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (mem_done) break;
    end
    chk("latency", 33'(n), 33'(LAT));
    req = 1'b0;
    e = sbq.pop_front();
    if (e.full) chk("load_data", read_data, e.exp);
    else        chk("data_valid", 33'(read_data[32]), 33'(e.exp[32]));
`ifdef MEM_MISALIGN_TRAP_EN
    chk("misalign_err", 33'(misalign_err), 33'(e.mis));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int pulses;
    bit seen;

    vt[0]  = '{0, 1, SW,  32'h0000_0100, 32'hDEAD_BEEF, 0, 33'h0_0000_0000, 0};
    vt[1]  = '{1, 0, LW,  32'h0000_0100, 32'h0,         1, 33'h1_DEAD_BEEF, 0};
    vt[2]  = '{1, 0, LB,  32'h0000_0103, 32'h0,         1, 33'h1_FFFF_FFDE, 0};
    vt[3]  = '{1, 0, LBU, 32'h0000_0103, 32'h0,         1, 33'h1_0000_00DE, 0};
    vt[4]  = '{1, 0, LH,  32'h0000_0102, 32'h0,         1, 33'h1_FFFF_DEAD, 0};
    vt[5]  = '{1, 0, LHU, 32'h0000_0100, 32'h0,         1, 33'h1_0000_BEEF, 0};
    vt[6]  = '{0, 1, SB,  32'h0000_0101, 32'hFFFF_FF55, 0, 33'h0_0000_0000, 0};
    vt[7]  = '{1, 0, LW,  32'h0000_0100, 32'h0,         1, 33'h1_DEAD_55EF, 0};
    vt[8]  = '{1, 0, LB,  32'h0000_0101, 32'h0,         1, 33'h1_0000_0055, 0};
    vt[9]  = '{1, 0, LB,  32'h0000_0100, 32'h0,         1, 33'h1_FFFF_FFEF, 0};
    vt[10] = '{0, 1, SW,  32'h0000_0300, 32'h1122_3344, 0, 33'h0_0000_0000, 0};
    vt[11] = '{0, 1, SH,  32'h0000_0302, 32'hABCD_8001, 0, 33'h0_0000_0000, 0};
    vt[12] = '{1, 0, LW,  32'h0000_0300, 32'h0,         1, 33'h1_8001_3344, 0};
    vt[13] = '{1, 0, LH,  32'h0000_0302, 32'h0,         1, 33'h1_FFFF_8001, 0};
    vt[14] = '{1, 0, LW,  32'h1000_0100, 32'h0,         1, 33'h1_DEAD_55EF, 0};
    vt[15] = '{1, 0, 6'd30, 32'h0000_0100, 32'h0,       0, 33'h0_0000_0000, 0};
    vt[16] = '{1, 0, SW,  32'h0000_0100, 32'h0,         0, 33'h0_0000_0000, 0};
    vt[17] = '{0, 1, LW,  32'h0000_0100, 32'h0,         0, 33'h0_0000_0000, 0};
    vt[18] = '{1, 0, LW,  32'h0000_0100, 32'h0,         1, 33'h1_DEAD_55EF, 0};
    vt[19] = '{0, 1, SW,  32'h0000_0200, 32'hCAFE_F00D, 0, 33'h0_0000_0000, 0};

    rst = 1'b1; req = 1'b0; read_mem = 1'b0; write_mem = 1'b0;
    ex_type = 6'd0; addr = 32'd0; write_data = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_done", 33'(mem_done), 33'd0);
    chk("rst_busy", 33'(busy), 33'd0);
    chk("rst_read_data", read_data, 33'd0);
    rst = 1'b0;

    for (int i = 0; i < 20; i++)
      do_req(vt[i].rd, vt[i].wr, vt[i].op, vt[i].a, vt[i].wd, vt[i].full, vt[i].exp, vt[i].mis);

    // Both direction strobes high: must be ignored.
    @(negedge clk);
    req = 1'b1; read_mem = 1'b1; write_mem = 1'b1; ex_type = LW; addr = 32'h100;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (busy || mem_done) seen = 1'b1;
    end
    req = 1'b0; write_mem = 1'b0;
    chk("dual_no_accept", 33'(seen), 33'd0);

    // req held through RESP: exactly one completion.
    @(negedge clk);
    req = 1'b1; read_mem = 1'b1; write_mem = 1'b0; ex_type = LW; addr = 32'h300;
    wait_accept(ok);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (mem_done) pulses++;
      else if (pulses > 0 && req) req = 1'b0;
    end
    req = 1'b0;
    chk("held_req_pulses", 33'(pulses), 33'd1);
    chk("held_req_idle", 33'(busy), 33'd0);
    chk("held_req_data", read_data, 33'h1_8001_3344);
    do_req(1, 0, LBU, 32'h300, 32'h0, 1, 33'h1_0000_0044, 0);

    // Reset one cycle after accepting a store aborts it.
    @(negedge clk);
    req = 1'b1; read_mem = 1'b0; write_mem = 1'b1; ex_type = SW;
    addr = 32'h200; write_data = 32'h1234_5678;
    wait_accept(ok);
    @(negedge clk);
    rst = 1'b1; req = 1'b0; write_mem = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", 33'(busy), 33'd0);
    chk("abort_read_data", read_data, 33'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (mem_done) pulses++;
    end
    chk("abort_no_done", 33'(pulses), 33'd0);
    do_req(1, 0, LW, 32'h200, 32'h0, 1, 33'h1_CAFE_F00D, 0);

    // Misaligned word store and half load.
`ifdef MEM_MISALIGN_TRAP_EN
    do_req(0, 1, SW, 32'h102, 32'h0BAD_F00D, 0, 33'h0_0000_0000, 1);
    do_req(1, 0, LW, 32'h100, 32'h0,         1, 33'h1_DEAD_55EF, 0);
    do_req(1, 0, LH, 32'h101, 32'h0,         0, 33'h0_0000_0000, 1);
`else
    do_req(0, 1, SW, 32'h102, 32'h0BAD_F00D, 0, 33'h0_0000_0000, 0);
    do_req(1, 0, LW, 32'h100, 32'h0,         1, 33'h1_0BAD_F00D, 0);
    do_req(1, 0, LH, 32'h101, 32'h0,         1, 33'h1_FFFF_F00D, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
